// File: rtl/hd_secded_pkg.sv
// Shared definitions for the streaming Hamming SEC-DED codec.
//
// The helpers below work on fixed maximum-width vectors, and the actual
// payload width is passed in as an argument. A module calls them with its own
// elaboration-time width and then slices the result. The localparams at the
// bottom describe the default 12-bit configuration.
//
// Codeword layout: bit 0 holds the even overall parity over bits 1..CW_W-1.
// Positions 1..CW_W-1 are Hamming-numbered. Check bits sit at the powers of
// two, and data bits fill the remaining positions in ascending order,
// LSB first.
package hd_secded_pkg;

  localparam int MAX_DATA_W = 64;
  localparam int MAX_CW_W   = 128;
  localparam int MAX_POS_W  = 7;

  typedef logic [MAX_DATA_W-1:0] data_max_t;
  typedef logic [MAX_CW_W-1:0]   cw_max_t;
  typedef logic [MAX_POS_W-1:0]  pos_max_t;

  typedef enum logic [1:0] {
    ST_CLEAN  = 2'd0,
    ST_CORR   = 2'd1,
    ST_UNCORR = 2'd2
  } secded_status_e;

  function automatic bit secded_is_pow2(input int x);
    return (x > 0) && ((x & (x - 1)) == 0);
  endfunction

  // Smallest p with 2**p >= data_w + p + 1. The scan runs downward, so the
  // last hit is the minimum.
  function automatic int secded_parity_bits(input int data_w);
    int p;
    p = 0;
    for (int i = 16; i >= 1; i--)
      if ((1 << i) >= data_w + i + 1) p = i;
    return p;
  endfunction

  // Codeword position that carries data bit idx.
  function automatic int secded_data_pos(input int idx);
    int n;
    int pos;
    n   = 0;
    pos = 0;
    for (int p = 3; p < MAX_CW_W; p++) begin
      if (!secded_is_pow2(p)) begin
        if (n == idx) pos = p;
        n++;
      end
    end
    return pos;
  endfunction

  // Data bit index held at codeword position pos, or -1 for a check/parity bit.
  function automatic int secded_data_idx(input int pos);
    int n;
    n = 0;
    if (pos == 0 || secded_is_pow2(pos)) return -1;
    for (int p = 3; p < MAX_CW_W; p++)
      if (p < pos && !secded_is_pow2(p)) n++;
    return n;
  endfunction

  // XOR of the indices of all set bits in positions 1..cw_w-1.
  function automatic pos_max_t secded_syndrome(input cw_max_t cw, input int cw_w);
    pos_max_t s;
    s = '0;
    for (int pos = 1; pos < MAX_CW_W; pos++)
      if (pos < cw_w && cw[pos]) s ^= pos_max_t'(pos);
    return s;
  endfunction

  function automatic data_max_t secded_extract(input cw_max_t cw, input int data_w);
    data_max_t d;
    d = '0;
    for (int i = 0; i < MAX_DATA_W; i++)
      if (i < data_w) d[i] = cw[secded_data_pos(i)];
    return d;
  endfunction

  // Place the data bits first. The syndrome of that partial word is then
  // exactly the set of check bits needed: each check bit sits at a power of
  // two, so writing it cancels its own syndrome bit and nothing else.
  function automatic cw_max_t secded_encode(input data_max_t data, input int data_w);
    cw_max_t  cw;
    pos_max_t s;
    int       cw_w;
    cw_w = data_w + secded_parity_bits(data_w) + 1;
    cw   = '0;
    for (int i = 0; i < MAX_DATA_W; i++)
      if (i < data_w) cw[secded_data_pos(i)] = data[i];
    s = secded_syndrome(cw, cw_w);
    for (int k = 0; k < MAX_POS_W; k++)
      if ((1 << k) < cw_w) cw[1 << k] = s[k];
    cw[0] = ^cw;
    return cw;
  endfunction

  localparam int P     = secded_parity_bits(12);
  localparam int CW_W  = 12 + P + 1;
  localparam int POS_W = $clog2(CW_W);

endpackage

// File: rtl/hd_secded_decode.sv
// Combinational SEC-DED classify/correct for one codeword.
//
// Ports:
//   cw        in   CODE_W  received codeword (bit 0 = overall parity)
//   data      out  DATA_W  corrected payload; the raw bits when uncorrectable
//   corr      out  1       single error found and corrected
//   uncorr    out  1       double error or out-of-range syndrome
//   syndrome  out  SYN_W   raw Hamming syndrome
module hd_secded_decode
  import hd_secded_pkg::*;
#(
  parameter int DATA_W = 12,
  parameter int SYN_W  = secded_parity_bits(DATA_W),
  parameter int CODE_W = DATA_W + SYN_W + 1
) (
  input  logic [CODE_W-1:0] cw,
  output logic [DATA_W-1:0] data,
  output logic              corr,
  output logic              uncorr,
  output logic [SYN_W-1:0]  syndrome
);

  cw_max_t        cw_ext;
  cw_max_t        cw_fix;
  pos_max_t       syn;
  data_max_t      fixed;
  logic           parity;
  secded_status_e status;

  // NOTE: every variable gets a default before any branch, so no path
  // through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    cw_ext             = '0;
    cw_ext[CODE_W-1:0] = cw;
    syn                = secded_syndrome(cw_ext, CODE_W);
    parity             = ^cw;
    cw_fix             = cw_ext;
    status             = ST_CLEAN;

    if (!parity) begin
      status = (syn == '0) ? ST_CLEAN : ST_UNCORR;
    end else if (syn >= pos_max_t'(CODE_W)) begin
      status = ST_UNCORR;
    end else begin
      // A zero syndrome means the overall parity bit itself flipped. Toggling
      // bit 0 is harmless because it carries no data.
      status      = ST_CORR;
      cw_fix[syn] = ~cw_ext[syn];
    end

    // On an uncorrectable word cw_fix is still the received word, so this
    // extract returns the raw bits.
    fixed    = secded_extract(cw_fix, DATA_W);
    data     = fixed[DATA_W-1:0];
    corr     = (status == ST_CORR);
    uncorr   = (status == ST_UNCORR);
    syndrome = syn[SYN_W-1:0];
  end

  // Bits above DATA_W in the max-width helper result are don't-care.
  // Folding them into one named bit marks them as deliberately unused.
  logic unused_fixed_bits;
  assign unused_fixed_bits = ^fixed;

endmodule

// File: rtl/hd_secded_stream.sv
// Streaming SEC-DED loopback codec (self-test).
// Stage 1 encodes an accepted word and applies the fault-injection mask.
// Stage 2 decodes it and registers the result onto out_*. The pipeline has
// 2-cycle latency and a throughput of one word per cycle. A stalled output
// freezes both stages.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready/in_data input handshake and payload
//   inj_en/inj_double/inj_pos0/inj_pos1
//                             per-word fault injection, sampled on accept
//   out_valid/out_ready/out_data/out_corr/out_uncorr/out_syndrome
//                             output handshake and decode status
//   cnt_clr                   clear both statistics counters
//   cnt_corr/cnt_uncorr       saturating counts of corrected/uncorrectable
//                             output transfers
module hd_secded_stream
  import hd_secded_pkg::*;
#(
  parameter  int DATA_W = 12,
  parameter  int CNT_W  = 16,
  localparam int SYN_W  = secded_parity_bits(DATA_W),
  localparam int CODE_W = DATA_W + SYN_W + 1,
  localparam int IDX_W  = $clog2(CODE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic              inj_double,
  input  logic [IDX_W-1:0]  inj_pos0,
  input  logic [IDX_W-1:0]  inj_pos1,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_corr,
  output logic              out_uncorr,
  output logic [SYN_W-1:0]  out_syndrome,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_corr,
  output logic [CNT_W-1:0]  cnt_uncorr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              stall;
  logic              accept;
  logic              xfer;
  data_max_t         data_ext;
  cw_max_t           cw_enc;
  logic [CODE_W-1:0] inj_mask;

  logic              s1_valid;
  logic [CODE_W-1:0] s1_cw;

  logic [DATA_W-1:0] dec_data;
  logic              dec_corr;
  logic              dec_uncorr;
  logic [SYN_W-1:0]  dec_syn;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid & out_ready;

  // Each mask bit compares its own index against the requested positions.
  // A position at or beyond CODE_W matches no bit. The XOR makes a repeated
  // position cancel, so the same bit given twice flips nothing.
  always_comb begin
    data_ext           = '0;
    data_ext[DATA_W-1:0] = in_data;
    cw_enc             = secded_encode(data_ext, DATA_W);
    for (int i = 0; i < CODE_W; i++)
      inj_mask[i] = inj_en & ((inj_pos0 == IDX_W'(i)) ^
                              (inj_double & (inj_pos1 == IDX_W'(i))));
  end

  logic unused_enc_bits;
  assign unused_enc_bits = ^cw_enc;

  // NOTE: the codeword register is plain datapath and has no reset.
  // s1_valid qualifies it, and that flag is the one that gets reset.
  always_ff @(posedge clk) begin
    if (accept) s1_cw <= cw_enc[CODE_W-1:0] ^ inj_mask;
  end

  hd_secded_decode #(
    .DATA_W (DATA_W),
    .SYN_W  (SYN_W),
    .CODE_W (CODE_W)
  ) u_decode (
    .cw       (s1_cw),
    .data     (dec_data),
    .corr     (dec_corr),
    .uncorr   (dec_uncorr),
    .syndrome (dec_syn)
  );

  // NOTE: state registers use non-blocking assignments, so every flop
  // samples the values present before this edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid     <= 1'b0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_corr     <= 1'b0;
      out_uncorr   <= 1'b0;
      out_syndrome <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= dec_data;
        out_corr     <= dec_corr;
        out_uncorr   <= dec_uncorr;
        out_syndrome <= dec_syn;
      end
    end
  end

  // The clear is checked before the increment, so it wins over a transfer
  // in the same cycle.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      cnt_corr   <= '0;
      cnt_uncorr <= '0;
    end else if (xfer) begin
      if (out_corr && cnt_corr != CNT_MAX)     cnt_corr   <= cnt_corr + 1'b1;
      if (out_uncorr && cnt_uncorr != CNT_MAX) cnt_uncorr <= cnt_uncorr + 1'b1;
    end
  end

endmodule

// File: tb/tb_hd_secded_stream.sv
// Self-checking bench for hd_secded_stream (DATA_W=12).
// Two instances share all inputs: one with CNT_W=16 and one with CNT_W=3,
// so counter saturation is reachable. The reference model predicts each
// word's result from the set of codeword bits actually flipped:
//   no flip      -> clean
//   one flip     -> corrected, syndrome = that position
//   two flips    -> uncorrectable, syndrome = XOR of the two positions,
//                   and any data bits at those positions stay inverted.
module tb_hd_secded_stream;

  localparam int DW = 12;
  localparam int SW = 5;
  localparam int CW = 18;
  localparam int PW = 5;

  typedef struct {
    logic [DW-1:0] data;
    logic          corr;
    logic          uncorr;
    logic [SW-1:0] syn;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, inj_en, inj_double, out_ready, cnt_clr;
  logic [DW-1:0] in_data;
  logic [PW-1:0] inj_pos0, inj_pos1;

  logic          in_ready, out_valid, out_corr, out_uncorr;
  logic [DW-1:0] out_data;
  logic [SW-1:0] out_syndrome;
  logic [15:0]   cnt_corr, cnt_uncorr;

  logic          s_in_ready, s_out_valid, s_out_corr, s_out_uncorr;
  logic [DW-1:0] s_out_data;
  logic [SW-1:0] s_out_syndrome;
  logic [2:0]    s_cnt_corr, s_cnt_uncorr;

  hd_secded_stream #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_double(inj_double), .inj_pos0(inj_pos0), .inj_pos1(inj_pos1),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_corr(out_corr),
    .out_uncorr(out_uncorr), .out_syndrome(out_syndrome), .cnt_clr(cnt_clr),
    .cnt_corr(cnt_corr), .cnt_uncorr(cnt_uncorr)
  );

  hd_secded_stream #(.DATA_W(DW), .CNT_W(3)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .inj_en(inj_en), .inj_double(inj_double), .inj_pos0(inj_pos0), .inj_pos1(inj_pos1),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .out_corr(s_out_corr),
    .out_uncorr(s_out_uncorr), .out_syndrome(s_out_syndrome), .cnt_clr(cnt_clr),
    .cnt_corr(s_cnt_corr), .cnt_uncorr(s_cnt_uncorr)
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t exp_q[$];
  int   m_corr, m_uncorr, ms_corr, ms_uncorr;
  int   n_xfer = 0;
  bit   last_accept;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Data bit index stored at a Hamming position, or -1 for a check/parity bit.
  // Positions 1..pos include floor(log2(pos))+1 powers of two, and position 0
  // is the overall parity bit.
  function automatic int data_idx(input int pos);
    if (pos == 0 || (pos & (pos - 1)) == 0) return -1;
    return pos - 2 - ($clog2(pos + 1) - 1);
  endfunction

  function automatic exp_t model(input logic [DW-1:0] d, input logic en, input logic dbl,
                                 input int p0, input int p1);
    int   flips[$];
    exp_t e;
    if (en && p0 < CW) flips.push_back(p0);
    if (en && dbl && p1 < CW) begin
      if (flips.size() == 1 && flips[0] == p1) flips.delete();
      else flips.push_back(p1);
    end
    e.data   = d;
    e.corr   = 1'b0;
    e.uncorr = 1'b0;
    e.syn    = '0;
    if (flips.size() == 1) begin
      e.corr = 1'b1;
      e.syn  = SW'(flips[0]);
    end else if (flips.size() == 2) begin
      e.uncorr = 1'b1;
      e.syn    = SW'(flips[0] ^ flips[1]);
      foreach (flips[k]) if (data_idx(flips[k]) >= 0) e.data[data_idx(flips[k])] ^= 1'b1;
    end
    return e;
  endfunction

  // Runs just after the inputs are driven and before the next rising edge.
  // It checks the visible state and then advances the model by that edge.
  task automatic sample();
    exp_t e;
    #1;
    last_accept = 1'b0;
    if (rst) begin
      exp_q.delete();
      m_corr = 0; m_uncorr = 0; ms_corr = 0; ms_uncorr = 0;
      return;
    end
    check("cnt_corr", cnt_corr, m_corr);
    check("cnt_uncorr", cnt_uncorr, m_uncorr);
    check("s_cnt_corr", s_cnt_corr, ms_corr);
    check("s_cnt_uncorr", s_cnt_uncorr, ms_uncorr);
    check("in_ready", in_ready, !(out_valid && !out_ready));
    check("s_in_ready", s_in_ready, !(s_out_valid && !out_ready));
    if (exp_q.size() == 0) begin
      check("idle_valid", out_valid, 0);
      check("s_idle_valid", s_out_valid, 0);
    end else begin
      e = exp_q[0];
      if (out_valid) begin
        check("out_data", out_data, e.data);
        check("out_corr", out_corr, e.corr);
        check("out_uncorr", out_uncorr, e.uncorr);
        check("out_syndrome", out_syndrome, e.syn);
      end
      if (s_out_valid) begin
        check("s_out_data", s_out_data, e.data);
        check("s_out_flags", {s_out_corr, s_out_uncorr, s_out_syndrome}, {e.corr, e.uncorr, e.syn});
      end
    end
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_xfer++;
      if (e.corr) begin
        if (m_corr < 65535) m_corr++;
        if (ms_corr < 7) ms_corr++;
      end
      if (e.uncorr) begin
        if (m_uncorr < 65535) m_uncorr++;
        if (ms_uncorr < 7) ms_uncorr++;
      end
    end
    if (cnt_clr) begin
      m_corr = 0; m_uncorr = 0; ms_corr = 0; ms_uncorr = 0;
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(in_data, inj_en, inj_double, int'(inj_pos0), int'(inj_pos1)));
      last_accept = 1'b1;
    end
  endtask

  task automatic tick();
    sample();
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic en, input logic dbl,
                       input logic [PW-1:0] p0, input logic [PW-1:0] p1);
    in_valid   = v;
    in_data    = d;
    inj_en     = en;
    inj_double = dbl;
    inj_pos0   = p0;
    inj_pos1   = p1;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
    cnt_clr = 1'b0;
  endtask

  // Sends one word with no backpressure, checks the 2-cycle latency and the
  // expected result, and lets the word transfer.
  task automatic send_one(input string tag, input logic [DW-1:0] d, input logic en,
                          input logic dbl, input logic [PW-1:0] p0, input logic [PW-1:0] p1,
                          input logic [DW-1:0] xd, input logic xc, input logic xu,
                          input logic [SW-1:0] xs);
    int lat;
    out_ready = 1'b1;
    drive(1'b1, d, en, dbl, p0, p1);
    tick();
    idle();
    lat = 1;
    while (!out_valid && lat < 8) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, 2);
    check({tag, "_data"}, out_data, xd);
    check({tag, "_flags"}, {out_corr, out_uncorr}, {xc, xu});
    check({tag, "_syn"}, out_syndrome, xs);
    tick();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && t < 50) begin
      tick();
      t++;
    end
    check("drain_empty", exp_q.size(), 0);
    tick();
  endtask

  logic [DW-1:0] burst[10];
  int            idx, t, x0;

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    idle();
    do_reset();

    // Clean word, single errors (data bit and overall parity bit), double error, cancelled pair.
    send_one("t1_clean", 12'hABC, 0, 0, 0, 0, 12'hABC, 0, 0, 5'd0);
    send_one("t2_pos5", 12'hABC, 1, 0, 5, 0, 12'hABC, 1, 0, 5'd5);
    send_one("t2_pos0", 12'hABC, 1, 0, 0, 0, 12'hABC, 1, 0, 5'd0);
    send_one("t3_dbl", 12'h5A5, 1, 1, 3, 9, 12'h5B4, 0, 1, 5'd10);
    send_one("t3_same", 12'h5A5, 1, 1, 7, 7, 12'h5A5, 0, 0, 5'd0);
    send_one("t3_oob", 12'h123, 1, 0, 20, 0, 12'h123, 0, 0, 5'd0);

    // 10-word burst with the output stalled during cycles 4-6.
    foreach (burst[i]) burst[i] = DW'($urandom);
    idx = 0; t = 0; x0 = n_xfer;
    while ((idx < 10 || exp_q.size() > 0) && t < 60) begin
      out_ready = !(t >= 4 && t <= 6);
      if (idx < 10) drive(1'b1, burst[idx], 1'b0, 1'b0, '0, '0);
      else in_valid = 1'b0;
      tick();
      if (last_accept) idx++;
      t++;
    end
    check("t4_accepted", idx, 10);
    check("t4_delivered", n_xfer - x0, 10);

    // Saturation of the 3-bit counter, then a clear that wins over a corrected transfer.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, DW'($urandom), 1'b1, 1'b0, PW'($urandom_range(1, CW - 1)), '0);
      tick();
    end
    drain();
    check("t5_sat", s_cnt_corr, 7);
    check("t5_big", cnt_corr, 9);
    drive(1'b1, 12'h0F0, 1'b1, 1'b0, 5'd6, '0);
    for (int i = 0; i < 10; i++) begin
      cnt_clr = out_valid;
      tick();
      in_valid = 1'b0;
      if (cnt_clr) break;
    end
    cnt_clr = 1'b0;
    check("t5_clr", s_cnt_corr, 0);
    check("t5_clr_big", cnt_corr, 0);

    // Reset with two words in flight.
    send_one("t6_pre", 12'h321, 1, 0, 3, 0, 12'h321, 1, 0, 5'd3);
    drive(1'b1, 12'h111, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1'b1, 12'h222, 1'b0, 1'b0, '0, '0);
    tick();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_out_valid", out_valid, 0);
    check("t6_cnt", {cnt_corr, cnt_uncorr}, 0);
    for (int i = 0; i < 5; i++) tick();

    // Random regression against the reference model.
    for (int i = 0; i < 20000; i++) begin
      drive($urandom_range(0, 9) < 8, DW'($urandom), $urandom_range(0, 3) != 0,
            1'($urandom), PW'($urandom_range(0, 23)), PW'($urandom_range(0, 23)));
      out_ready = $urandom_range(0, 3) != 0;
      cnt_clr   = $urandom_range(0, 499) == 0;
      rst       = $urandom_range(0, 4999) == 0;
      tick();
    end
    rst = 1'b0;
    idle();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
